// File: rtl/dwa_element_scheduler.sv
// Element scheduler for a 6-element unit-cell DAC: each accepted beta code becomes a
// registered enable word, either a thermometer fill or a rotating DWA selection.
module dwa_element_scheduler #(
    parameter int         N_ELEM   = 6,
    parameter logic [2:0] PTR_INIT = 3'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    input  logic [2:0] s,
    input  logic       dwa_en,
    output logic [5:0] DataOut,
    output logic       out_valid,
    output logic [2:0] ptr,
    output logic       err,
    output logic [7:0] err_cnt
);

    // Handshake: no backpressure. A code is taken on every rising edge with s_valid=1
    // (unless rst=1), and out_valid marks the cycle in which its result is on DataOut.

    logic [2:0] r_ptr;
    logic [5:0] r_data;
    logic       r_valid;
    logic       r_err;
    logic [7:0] r_err_cnt;
    logic       r_mode;

    logic       w_illegal;
    logic [2:0] w_base;
    logic [3:0] w_sum;
    logic [2:0] w_ptr_next;
    logic [5:0] w_therm;
    logic [5:0] w_rot;

    assign w_illegal = (s == 3'd7);

    // The mode register only changes on legal codes, so after any static sample
    // the next DWA selection starts at PTR_INIT.
    assign w_base = r_mode ? r_ptr : PTR_INIT;

    assign w_sum      = {1'b0, w_base} + {1'b0, s};
    assign w_ptr_next = 3'((w_sum >= 4'(N_ELEM)) ? (w_sum - 4'(N_ELEM)) : w_sum);

    always_comb begin
        w_therm = '0;
        w_rot   = '0;
        for (int j = 0; j < N_ELEM; j++) begin
            int d;
            w_therm[j] = (j < int'(s));
            // Distance of element j ahead of the base pointer, modulo N_ELEM.
            d = j + N_ELEM - int'(w_base);
            if (d >= N_ELEM) d = d - N_ELEM;
            w_rot[j] = (d < int'(s));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= PTR_INIT;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
            r_mode    <= 1'b0;
        end else begin
            r_valid <= s_valid;
            r_err   <= s_valid && w_illegal;
            if (s_valid) begin
                if (w_illegal) begin
                    r_data <= '0;
                    if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                end else if (dwa_en) begin
                    r_data <= w_rot;
                    r_ptr  <= w_ptr_next;
                    r_mode <= 1'b1;
                end else begin
                    r_data <= w_therm;
                    r_ptr  <= PTR_INIT;
                    r_mode <= 1'b0;
                end
            end
        end
    end

    assign DataOut   = r_data;
    assign out_valid = r_valid;
    assign ptr       = r_ptr;
    assign err       = r_err;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_dwa_element_scheduler.sv
// Directed bench for dwa_element_scheduler: hand-computed DWA/static vectors,
// illegal-code handling, err_cnt saturation and mid-stream reset.
module tb_dwa_element_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic [2:0] s;
    logic       dwa_en;
    logic [5:0] DataOut;
    logic       out_valid;
    logic [2:0] ptr;
    logic       err;
    logic [7:0] err_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dwa_element_scheduler #(.N_ELEM(6), .PTR_INIT(3'd0)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s         (s),
        .dwa_en    (dwa_en),
        .DataOut   (DataOut),
        .out_valid (out_valid),
        .ptr       (ptr),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks DataOut, out_valid, ptr and err in one go.
    task automatic chk_out(input string tag, input logic [5:0] d, input logic v,
                           input logic [2:0] p, input logic e);
        chk({tag, ".data"}, {2'b00, DataOut}, {2'b00, d});
        chk({tag, ".valid"}, {7'd0, out_valid}, {7'd0, v});
        chk({tag, ".ptr"}, {5'd0, ptr}, {5'd0, p});
        chk({tag, ".err"}, {7'd0, err}, {7'd0, e});
    endtask

    // Drive one cycle of inputs at the falling edge, then sample #1 after the rising edge.
    task automatic cyc(input logic r, input logic v, input logic [2:0] code, input logic en);
        @(negedge clk);
        rst     = r;
        s_valid = v;
        s       = code;
        dwa_en  = en;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s = 3'd0; dwa_en = 1'b0;
        cyc(1, 0, 0, 0);
        cyc(1, 1, 3, 1);
        chk_out("reset", 6'b000000, 0, 3'd0, 0);
        chk("reset.cnt", err_cnt, 8'd0);

        // DWA 3,3,2 back to back
        cyc(0, 1, 3, 1); chk_out("dwa_a", 6'b000111, 1, 3'd3, 0);
        cyc(0, 1, 3, 1); chk_out("dwa_b", 6'b111000, 1, 3'd0, 0);
        cyc(0, 1, 2, 1); chk_out("dwa_c", 6'b000011, 1, 3'd2, 0);
        cyc(0, 0, 5, 1); chk_out("idle_hold", 6'b000011, 0, 3'd2, 0);

        // Boundaries at ptr=2
        cyc(0, 1, 6, 1); chk_out("full_k6", 6'b111111, 1, 3'd2, 0);
        cyc(0, 1, 0, 1); chk_out("zero_k0", 6'b000000, 1, 3'd2, 0);

        // Wrap case: back to 0, then 4 and 0 to reach ptr=4, then 5
        cyc(0, 1, 4, 1); chk_out("to_ptr0", 6'b111100, 1, 3'd0, 0);
        cyc(0, 1, 4, 1); chk_out("to_ptr4", 6'b001111, 1, 3'd4, 0);
        cyc(0, 1, 0, 1); chk_out("hold4", 6'b000000, 1, 3'd4, 0);
        cyc(0, 1, 5, 1); chk_out("wrap5", 6'b110111, 1, 3'd3, 0);

        // Illegal code at ptr=3
        cyc(0, 1, 7, 1); chk_out("illegal", 6'b000000, 1, 3'd3, 1);
        chk("illegal.cnt", err_cnt, 8'd1);
        cyc(0, 0, 0, 1); chk_out("err_drop", 6'b000000, 0, 3'd3, 0);

        // Static mode, then switch to DWA
        cyc(0, 1, 1, 0); chk_out("stat1", 6'b000001, 1, 3'd0, 0);
        cyc(0, 1, 4, 0); chk_out("stat4", 6'b001111, 1, 3'd0, 0);
        cyc(0, 1, 6, 0); chk_out("stat6", 6'b111111, 1, 3'd0, 0);
        cyc(0, 1, 2, 1); chk_out("to_dwa", 6'b000011, 1, 3'd2, 0);

        // DWA then static in consecutive samples: static takes effect immediately
        cyc(0, 1, 3, 1); chk_out("dwa_pre", 6'b011100, 1, 3'd5, 0);
        cyc(0, 1, 2, 0); chk_out("to_stat", 6'b000011, 1, 3'd0, 0);

        // Reset mid-stream with a sample in the reset cycle
        cyc(0, 1, 4, 1); chk_out("pre_rst", 6'b001111, 1, 3'd4, 0);
        chk("pre_rst.cnt", err_cnt, 8'd1);
        cyc(1, 1, 3, 1); chk_out("mid_rst", 6'b000000, 0, 3'd0, 0);
        chk("mid_rst.cnt", err_cnt, 8'd0);
        cyc(0, 1, 2, 1); chk_out("post_rst", 6'b000011, 1, 3'd2, 0);

        // Saturation: 300 back-to-back illegal codes
        for (int i = 0; i < 254; i++) cyc(0, 1, 7, 1);
        chk("cnt254", err_cnt, 8'd254);
        chk_out("sat_mid", 6'b000000, 1, 3'd2, 1);
        for (int i = 0; i < 46; i++) cyc(0, 1, 7, 0);
        chk("cnt_sat", err_cnt, 8'd255);
        chk_out("sat_end", 6'b000000, 1, 3'd2, 1);
        cyc(0, 0, 0, 0);
        chk("cnt_hold", err_cnt, 8'd255);
        chk_out("sat_idle", 6'b000000, 0, 3'd2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dwa_element_scheduler.md
# dwa_element_scheduler

Dynamic-element-matching scheduler for the 6-element unit-cell DAC array. Each accepted 3-bit beta code (0..6) becomes a registered 6-bit element-enable word. In static mode the word is a plain thermometer fill. In DWA mode the word is a rotating data-weighted-averaging selection, so element mismatch is first-order noise-shaped. The block sits between the digital modulator output and the unit-element drivers, and replaces direct thermometer decoding when DEM is enabled.

## Interface
- N_ELEM, 6: number of unit elements. Fixed at 6; any other value is unsupported.
- PTR_INIT, 0: pointer value loaded on reset and on entry to static mode. Legal range 0..5.

- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  sample strobe; code is accepted on any rising edge where s_valid=1
- s  in  3  beta code, 0..6 legal; 7 illegal
- dwa_en  in  1  0 = static thermometer, 1 = DWA rotation; sampled with each accepted code
- DataOut  out  6  registered element-enable word; bit i drives unit element i
- out_valid  out  1  one-cycle pulse marking a freshly updated DataOut
- ptr  out  3  current rotation pointer, 0..5: the first element of the next DWA selection
- err  out  1  one-cycle pulse when an illegal code is accepted
- err_cnt  out  8  saturating count of illegal codes since reset

## Operation
- State: ptr register (0..5), DataOut register, err_cnt register, and a mode register holding the previous accepted dwa_en.
- Accepted sample with code k, 0 <= k <= 6:
  - Static mode (dwa_en=0): DataOut = lower k bits set (k=3 gives 000111). ptr loads PTR_INIT.
  - DWA mode (dwa_en=1): DataOut sets bits ptr, ptr+1, …, ptr+k-1, each index mod 6.
  - DWA pointer update: ptr_next = (ptr + k) mod 6. Compute it in 4 bits (max 5+6=11), then subtract 6 when the sum is >= 6. A single subtraction is sufficient.
  - k=0: DataOut=000000 and ptr is unchanged.
  - k=6: DataOut=111111 and ptr is unchanged, because a full wrap returns to the same index.
- Mode change 0→1: the first DWA sample starts from PTR_INIT, since static mode holds ptr at PTR_INIT.
- Mode change 1→0: takes effect on that same sample. ptr loads PTR_INIT.
- Illegal code 7, in either mode: DataOut=000000, ptr unchanged, err=1 for one cycle, err_cnt increments. err_cnt saturates at 255.
- No accepted sample (s_valid=0): DataOut, ptr and err_cnt hold; out_valid=0 and err=0.
- Rotation arithmetic never yields ptr=6 or ptr=7. Both values are unreachable; verification asserts this.

## Timing
- Reset (rst=1 at an edge): DataOut=000000, out_valid=0, ptr=PTR_INIT, err=0, err_cnt=0, mode register=0.
- rst has priority over s_valid. A sample presented in a reset cycle is dropped.
- Latency is 1 cycle. A code accepted at edge n appears on DataOut after edge n, with out_valid=1 during cycle n+1.
- The ptr output after edge n already reflects the update made by sample n.
- Throughput is one sample per clock. Back-to-back s_valid is allowed, with no stall and no backpressure.
- err asserts in the same cycle as the corresponding out_valid.
- Reset mid-stream clears the rotation history. The next sample after reset release starts at PTR_INIT.
- Outputs change only on rising clk edges. No combinational path exists from s, s_valid or dwa_en to any output.

## Test plan
- Reset, then DWA: codes 3, 3, 2 → DataOut 000111, 111000, 000011; ptr 3, 0, 2; out_valid pulses each cycle.
- DWA wrap case: drive ptr to 4 using codes 4 and 0, then code 5 → DataOut 110111, ptr 3.
- DWA boundaries at ptr=2: code 6 → DataOut 111111, ptr stays 2. Code 0 → DataOut 000000, ptr stays 2.
- Static mode: codes 1, 4, 6 → DataOut 000001, 001111, 111111; ptr held at 0. Switch to DWA with code 2 → DataOut 000011, ptr 2.
- Illegal code 7 at ptr=3 → DataOut 000000, err pulse, ptr stays 3, err_cnt 1. Drive 300 illegal codes → err_cnt saturates at 255.
- Reset mid-stream (ptr=4, s_valid=1 in the reset cycle) → all outputs take reset values and the sample is dropped. Next code 2 → DataOut 000011, ptr 2.
